// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the datapath request ports and the single-ported RAM.
// slave is the arbiter's view; master is the environment (datapath, control unit, RAM).
interface mem_arbiter_if;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ram_REN;
  logic        ram_WEN;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        busy;
  logic        err;

  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, busy, err
  );

  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  iload, ihit, dload, dhit, ram_REN, ram_WEN, ram_addr, ram_store, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Sequential fetch/data arbiter for a single-ported RAM: one registered access in flight,
// data before fetch, one-cycle hit pulses and a sticky watchdog trap for a silent RAM.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IREQ, DREQ, ERR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [31:0]       ram_addr_q, ram_addr_d;
  logic [31:0]       ram_store_q, ram_store_d;
  logic [31:0]       iload_q, iload_d;
  logic [31:0]       dload_q, dload_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              wait_expired;

  // The current cycle is the TIMEOUT-th cycle the access has waited.
  assign wait_expired = ({1'b0, cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        // The hit cycle is a dead cycle so the requester can retire its request.
        if (!ihit_q && !dhit_q) begin
          if (bus.dWEN) begin
            state_d     = DREQ;
            ram_addr_d  = bus.daddr;
            ram_store_d = bus.dstore;
            ram_wen_d   = 1'b1;
            ram_ren_d   = 1'b0;
            cnt_d       = '0;
          end else if (bus.dREN) begin
            state_d     = DREQ;
            ram_addr_d  = bus.daddr;
            ram_ren_d   = 1'b1;
            ram_wen_d   = 1'b0;
            cnt_d       = '0;
          end else if (bus.iREN && !bus.halt) begin
            state_d     = IREQ;
            ram_addr_d  = bus.iaddr;
            ram_ren_d   = 1'b1;
            ram_wen_d   = 1'b0;
            cnt_d       = '0;
          end
        end
      end

      IREQ, DREQ: begin
        if (bus.ram_ready) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          cnt_d     = '0;
          if (state_q == IREQ) begin
            ihit_d  = 1'b1;
            iload_d = bus.ram_load;
          end else begin
            dhit_d = 1'b1;
            if (!ram_wen_q) dload_d = bus.ram_load;
          end
        end else if (wait_expired) begin
          state_d   = ERR;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ERR: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        err_d     = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == IREQ) || (state_d == DREQ);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.ram_REN   = ram_ren_q;
  assign bus.ram_WEN   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_store = ram_store_q;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ihit      = ihit_q;
  assign bus.dhit      = dhit_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic CLK = 1'b0;
  logic RST;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef enum int {M_IDLE, M_FETCH, M_DATA, M_TRAP} mstate_t;

  // Model: what access is outstanding, how long it has waited, and the visible results.
  mstate_t     m_st;
  logic        m_write;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  logic        m_ihit, m_dhit;
  int          m_wait;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;
  int lat      = 1;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    bit hit_cycle;
    if (RST) begin
      m_st = M_IDLE; m_write = 1'b0; m_addr = '0; m_store = '0;
      m_iload = '0; m_dload = '0; m_ihit = 1'b0; m_dhit = 1'b0; m_wait = 0;
      return;
    end
    hit_cycle = m_ihit || m_dhit;
    m_ihit = 1'b0;
    m_dhit = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (!hit_cycle) begin
          if (bus.dWEN) begin
            m_st = M_DATA; m_write = 1'b1; m_addr = bus.daddr; m_store = bus.dstore; m_wait = 1;
          end else if (bus.dREN) begin
            m_st = M_DATA; m_write = 1'b0; m_addr = bus.daddr; m_wait = 1;
          end else if (bus.iREN && !bus.halt) begin
            m_st = M_FETCH; m_write = 1'b0; m_addr = bus.iaddr; m_wait = 1;
          end
        end
      end
      M_FETCH, M_DATA: begin
        if (bus.ram_ready) begin
          if (m_st == M_FETCH) begin
            m_ihit = 1'b1; m_iload = bus.ram_load;
          end else begin
            m_dhit = 1'b1;
            if (!m_write) m_dload = bus.ram_load;
          end
          m_st = M_IDLE;
        end else if (m_wait >= TIMEOUT) begin
          m_st = M_TRAP;
        end else begin
          m_wait++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic rst, input logic hlt, input logic iren, input logic [31:0] ia,
                      input logic dren, input logic dwen, input logic [31:0] da,
                      input logic [31:0] ds, input logic rdy, input logic [31:0] ld);
    RST = rst; bus.halt = hlt; bus.iREN = iren; bus.iaddr = ia; bus.dREN = dren;
    bus.dWEN = dwen; bus.daddr = da; bus.dstore = ds; bus.ram_ready = rdy; bus.ram_load = ld;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        check1("m_ram_REN", bus.ram_REN, (m_st == M_FETCH) || (m_st == M_DATA && !m_write));
        check1("m_ram_WEN", bus.ram_WEN, (m_st == M_DATA) && m_write);
        check32("m_ram_addr", bus.ram_addr, m_addr);
        check32("m_ram_store", bus.ram_store, m_store);
        check32("m_iload", bus.iload, m_iload);
        check32("m_dload", bus.dload, m_dload);
        check1("m_ihit", bus.ihit, m_ihit);
        check1("m_dhit", bus.dhit, m_dhit);
        check1("m_busy", bus.busy, (m_st == M_FETCH) || (m_st == M_DATA));
        check1("m_err", bus.err, m_st == M_TRAP);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cmp_en = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check1("rst_ren", bus.ram_REN, 1'b0);
    check32("rst_iload", bus.iload, 32'h0);
    check32("rst_addr", bus.ram_addr, 32'h0);

    // Single fetch, RAM answers in the third strobe cycle.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("f_ren1", bus.ram_REN, 1'b1);
    check32("f_addr", bus.ram_addr, 32'h40);
    idle_step();
    check1("f_ren2", bus.ram_REN, 1'b1);
    idle_step();
    check1("f_ren3", bus.ram_REN, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8C220004);
    check1("f_ihit", bus.ihit, 1'b1);
    check32("f_iload", bus.iload, 32'h8C220004);
    check1("f_ren_off", bus.ram_REN, 1'b0);
    idle_step();
    check1("f_ihit_pulse", bus.ihit, 1'b0);

    // Data wins over a simultaneous fetch; fetch follows after the dead hit cycle.
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    check32("p_daddr", bus.ram_addr, 32'h100);
    check1("p_busy", bus.busy, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11112222);
    check1("p_dhit", bus.dhit, 1'b1);
    check32("p_dload", bus.dload, 32'h11112222);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("p_hit_gap", bus.ram_REN, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check32("p_iaddr", bus.ram_addr, 32'h80);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE0001);
    check1("p_ihit", bus.ihit, 1'b1);
    idle_step();

    // Write beats read; dload untouched by the write completion.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'h0);
    check1("w_wen", bus.ram_WEN, 1'b1);
    check1("w_ren", bus.ram_REN, 1'b0);
    check32("w_store", bus.ram_store, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555);
    check1("w_dhit", bus.dhit, 1'b1);
    check32("w_dload_kept", bus.dload, 32'h11112222);
    idle_step();

    // Halt blocks fetches but not data; an in-flight fetch survives halt.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      check1("h_blocked", bus.ram_REN, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    check32("h_data_addr", bus.ram_addr, 32'h300);
    step(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77);
    check1("h_dhit", bus.dhit, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("h_still_blocked", bus.ram_REN, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check32("h_fetch_addr", bus.ram_addr, 32'h44);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
    check1("h_ihit", bus.ihit, 1'b1);
    check32("h_iload", bus.iload, 32'h99);
    idle_step();

    // Watchdog: silent RAM traps after TIMEOUT waiting cycles; only reset recovers.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      idle_step();
      check1("wd_not_yet", bus.err, 1'b0);
    end
    idle_step();
    check1("wd_err", bus.err, 1'b1);
    check1("wd_ren_off", bus.ram_REN, 1'b0);
    check1("wd_busy_off", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h1);
      check1("wd_sticky", bus.err, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("wd_rst_clear", bus.err, 1'b0);

    // Ready in the final allowed cycle completes normally.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h404, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hABCD);
    check1("wd_edge_dhit", bus.dhit, 1'b1);
    check1("wd_edge_noerr", bus.err, 1'b0);
    check32("wd_edge_dload", bus.dload, 32'hABCD);
    idle_step();

    // Reset in the middle of a write, then a normal fetch.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 32'h12345678, 1'b0, 32'h0);
    check1("r_wen", bus.ram_WEN, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check1("r_wen_clr", bus.ram_WEN, 1'b0);
    check32("r_store_clr", bus.ram_store, 32'h0);
    check32("r_dload_clr", bus.dload, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check32("r_fetch_addr", bus.ram_addr, 32'h48);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h31);
    check1("r_ihit", bus.ihit, 1'b1);
    idle_step();

    // Random traffic: RAM latency chosen per access, occasionally never answering.
    for (int n = 0; n < 4000; n++) begin
      logic rst_r, rdy;
      bit   active;
      active = (m_st == M_FETCH) || (m_st == M_DATA);
      if (active && m_wait == 1)
        lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(1, TIMEOUT));
      rst_r = ((m_st == M_TRAP) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 199) == 0);
      rdy   = active ? (m_wait == lat) : ($urandom_range(0, 7) == 0);
      step(rst_r, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           {$urandom_range(0, 255), 2'b00}, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, {$urandom_range(0, 255), 2'b00},
           $urandom, rdy, $urandom);
    end

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter sharing the single-ported RAM between the datapath's instruction-fetch port (iREN/iaddr) and data port (dREN/dWEN/daddr), driven by the control unit's iREN, dREN, dWEN and halt.
- Registers one request at a time and holds it on the RAM port until the RAM signals completion.
- Returns load data with one-cycle hit pulses.
- Data accesses have priority over fetch; a watchdog traps a RAM that never responds.

Parameters:
TIMEOUT, 255, max cycles a request may wait for ram_ready before the error trap (1..2^CNT_W-1)
CNT_W, 8, width of the wait counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
halt  in  1  from control unit; blocks new instruction fetches
iREN  in  1  instruction read request
iaddr  in  32  fetch address (word_t)
iload  out  32  fetched instruction
ihit  out  1  one-cycle fetch completion pulse
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data address
dstore  in  32  write data
dload  out  32  read data
dhit  out  1  one-cycle data completion pulse
ram_REN  out  1  RAM read strobe
ram_WEN  out  1  RAM write strobe
ram_addr  out  32  RAM address
ram_store  out  32  RAM write data
ram_load  in  32  RAM read data, valid with ram_ready
ram_ready  in  1  RAM access complete, one-cycle pulse
busy  out  1  high in IREQ/DREQ
err  out  1  sticky watchdog error

Behaviour:
- Reset, applied at the next CLK edge from any state, including mid-access:
  - state=IDLE.
  - All outputs 0: ram_*, iload, dload, ihit, dhit, busy, err.
  - Wait counter 0.
- States: IDLE, IREQ, DREQ, ERR. All outputs are registered.
- IDLE, sampled at the clock edge, only when ihit=0 and dhit=0 in that cycle. Requests are ignored during the hit cycle so a requester has one cycle to drop or replace its request.
  - dWEN=1 -> DREQ. Latch daddr and dstore. ram_WEN=1, ram_REN=0. If dREN=1 at the same time, the write wins.
  - else dREN=1 -> DREQ. Latch daddr. ram_REN=1.
  - else iREN=1 and halt=0 -> IREQ. Latch iaddr. ram_REN=1.
  - else stay in IDLE with ram strobes at 0.
  - ram_ready is ignored in IDLE.
- IREQ/DREQ:
  - ram_addr, ram_store and the strobes are held constant. Input changes are ignored.
  - The wait counter increments each cycle.
  - On ram_ready=1: the next edge goes to IDLE, clears the strobes and the counter, and pulses the matching hit (ihit or dhit) for exactly one cycle.
  - On ram_ready=1 for a read, dload or iload captures ram_load. A write leaves dload unchanged.
  - iload and dload hold their value until the next completion of the same type.
- Watchdog: if the counter reaches TIMEOUT with ram_ready=0, go to ERR.
  - ram_ready in that same cycle takes precedence: the access completes normally.
- ERR: strobes 0, err=1, busy=0, no hits. Exits only on RST.
- Latency:
  - Request sampled at edge 0 -> strobes high in cycle 1.
  - ram_ready in cycle k (k>=1) -> hit high in cycle k+1.
  - Earliest next request sample is the edge ending cycle k+2.
- halt:
  - Gates only new fetch acceptance. An in-flight IREQ completes with ihit.
  - Data requests are still served while halt=1.
- Simultaneous iREN and dREN at IDLE: data first. The fetch is accepted after dhit, provided iREN is still high.
- busy = (state is IREQ or DREQ).

Test Plan:
- Single fetch: iREN=1, iaddr=0x00000040; RAM returns 0x8C220004 with ram_ready 3 cycles after ram_REN -> ram_addr=0x40, ram_REN high for 3 cycles, ihit one cycle later, iload=0x8C220004.
- Priority: iREN=1 and dREN=1 (daddr=0x100) sampled at the same edge -> DREQ first, dhit, one idle hit cycle, then IREQ on iaddr; ihit after the fetch's ram_ready.
- Write vs read: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ram_WEN=1, ram_REN=0, ram_store=0xDEADBEEF; dhit pulses; dload unchanged.
- Halt: halt=1, iREN=1 for 10 cycles -> ram_REN stays 0, no ihit. A dREN during the halt is served. halt asserted mid-IREQ -> the fetch still completes.
- Watchdog: TIMEOUT=4, dREN, ram_ready never asserted -> ERR after 4 wait cycles; err=1, strobes 0, stays in ERR; RST -> err=0, IDLE.
- Reset mid-access: RST during DREQ with ram_WEN=1 -> next cycle all outputs 0, then a new iREN is served normally.
